load_writeback_unit: RTL and testbench
======================================

LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous, active-high: clk and rst.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- req_valid  in  1  load request offered
- req_ready  out  1  unit can accept a request (high only in IDLE)
- opcode  in  6  load opcode: LB 6'h20, LH 6'h21, LW 6'h23, LBU 6'h24, LHU 6'h25
- base  in  32  rs value (base address)
- offset  in  16  immediate; sign-extended before use
- dest  in  5  destination register number
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  32  memory read word
- RegWrite  out  1  register-file write strobe, one cycle
- rd  out  5  register-file write index
- write_data  out  32  extended load result
- err  out  1  one-cycle pulse: misaligned or unsupported opcode
- busy  out  1  high in any state other than IDLE

Function
REQ-003 The block SHALL be an FSM with states IDLE, MEM_REQ, MEM_WAIT and WRITEBACK.
REQ-004 A request SHALL be accepted on a clk edge where req_valid and req_ready are both high.
REQ-005 On acceptance the block SHALL register opcode, dest and ea = base + sign_extend(offset), computed modulo 2^32.
REQ-006 Acceptance of a supported, aligned request SHALL move IDLE -> MEM_REQ.
REQ-007 An unsupported opcode, LH/LHU with ea[0]=1, or LW with ea[1:0]!=0 SHALL instead:
- pulse err for one cycle on the next cycle;
- issue no memory request and no RegWrite;
- remain in IDLE.
REQ-008 In MEM_REQ, mem_req_valid SHALL be high and mem_addr stable until mem_req_ready is sampled high; the block then moves to MEM_WAIT.
REQ-009 In MEM_WAIT, the block SHALL capture mem_rdata on the first cycle with mem_rvalid high and move to WRITEBACK. The wait is unbounded.
REQ-010 mem_rvalid SHALL be ignored in every state other than MEM_WAIT.
REQ-011 Lane extraction SHALL be little-endian:
- byte = mem_rdata[8*ea[1:0] +: 8]
- halfword = mem_rdata[16*ea[1] +: 16]
REQ-012 Extension of the loaded value SHALL be:
- LB: sign-extend byte
- LBU: zero-extend byte
- LH: sign-extend halfword
- LHU: zero-extend halfword
- LW: full word
REQ-013 In WRITEBACK, RegWrite SHALL be high for exactly one cycle with rd = dest and write_data = extended value; the block then returns to IDLE.
REQ-014 When dest == 5'd0, the memory access SHALL still occur but RegWrite SHALL stay low, because r0 is hardwired to zero.
REQ-015 When RegWrite is low, write_data SHALL hold its last value; it SHALL NOT glitch.
REQ-016 Minimum latency SHALL be 3 cycles from acceptance to RegWrite: mem_req_ready already high, and mem_rvalid arriving the cycle after the request handshake.
REQ-017 The block SHALL process only one outstanding load; req_ready SHALL be low whenever busy is high.

Reset
REQ-018 While rst is high, the block SHALL go to IDLE immediately, independent of clk.
REQ-019 Reset values SHALL be:
- req_ready=1 (after reset release)
- mem_req_valid=0, RegWrite=0, err=0, busy=0
- rd=0, write_data=0, mem_addr=0
REQ-020 Reset asserted mid-operation SHALL abandon the load: no RegWrite afterwards, and late mem_rvalid SHALL be ignored.

Structure
REQ-021 The load opcode constants (6'h20, 6'h21, 6'h23, 6'h24, 6'h25) and the FSM state encoding SHALL live in the shared MIPS package/include used by the register file and the decoder.
REQ-022 Lane extraction plus extension (REQ-011/REQ-012) SHALL be one combinational sub-module named load_extend.

Verification
REQ-023 LBU: base=0x100, offset=0x0003, dest=14, mem_rdata=0x80_54_B2_2B -> mem_addr=0x100, RegWrite pulse, rd=14, write_data=0x00000080.
REQ-024 LB vs LBU sign test: LB with the same stimulus as REQ-023 -> write_data=0xFFFFFF80.
REQ-025 LHU/LH: ea=0x102 with mem_rdata=0x8001_1234 ->
- LHU write_data=0x00008001
- LH write_data=0xFFFF8001
REQ-026 Misaligned: LW with ea=0x101 -> err pulse, no mem_req_valid, no RegWrite; the next req_valid is accepted on the following cycle.
REQ-027 dest=0 LW ea=0x200 -> memory request issued, RegWrite never asserts, busy returns low.
REQ-028 Stalls and reset:
- mem_req_ready low for 5 cycles and mem_rvalid delayed 4 cycles -> mem_addr stable throughout, exactly one RegWrite.
- rst asserted in MEM_WAIT -> all outputs at reset values immediately; a later mem_rvalid causes no write.

Source files
------------

// File: rtl/load_writeback_unit_pkg.sv
// ============================================================================
// Module   : load_writeback_unit_pkg
// Brief    : Shared MIPS load definitions: opcodes, FSM encoding, fault check
// Revision : 1.0
// ============================================================================
`default_nettype none

package load_writeback_unit_pkg;

  // Load opcodes
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  // Load/writeback FSM encoding
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEM_REQ   = 2'd1,
    S_MEM_WAIT  = 2'd2,
    S_WRITEBACK = 2'd3
  } lsu_state_t;

  // True when the opcode is not a load we support, or the effective
  // address is not naturally aligned for the access size.
  function automatic logic load_fault(input logic [5:0] op, input logic [1:0] ea_lo);
    logic f;
    case (op)
      OP_LB, OP_LBU: f = 1'b0;
      OP_LH, OP_LHU: f = ea_lo[0];
      OP_LW:         f = |ea_lo;
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_writeback_unit_if.sv
// ============================================================================
// Module   : load_writeback_unit_if
// Brief    : Request, memory and register-file writeback signals of the
//            load/writeback unit; slave = the unit, master = its environment
// Revision : 1.0
// ============================================================================
`default_nettype none

interface load_writeback_unit_if;
  // Load request
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] offset;
  logic [4:0]  dest;
  // Memory read port
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // Register-file writeback and status
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        err;
  logic        busy;

  modport slave (
    input  req_valid, opcode, base, offset, dest,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr,
    output RegWrite, rd, write_data, err, busy
  );

  modport master (
    output req_valid, opcode, base, offset, dest,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr,
    input  RegWrite, rd, write_data, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/load_writeback_unit_load_extend.sv
// ============================================================================
// Module   : load_extend
// Brief    : Little-endian lane select plus sign/zero extension of a load
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_extend (
  input  logic [5:0]  opcode,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  output logic [31:0] value
);
  import load_writeback_unit_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword, then extend according to the opcode
  always_comb begin
    case (byte_sel)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = byte_sel[1] ? word[31:16] : word[15:0];
    case (opcode)
      OP_LB:   value = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  value = {24'h0, lane_b};
      OP_LH:   value = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  value = {16'h0, lane_h};
      default: value = word;
    endcase
  end
endmodule

`default_nettype wire

// File: rtl/load_writeback_unit.sv
// ============================================================================
// Module   : load_writeback_unit
// Brief    : Single-outstanding MIPS load unit: address generation, memory
//            read handshake, lane extension and register-file writeback
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_writeback_unit (
  input  logic                  clk,
  input  logic                  rst,
  load_writeback_unit_if.slave  bus
);
  import load_writeback_unit_pkg::*;

  lsu_state_t  state;
  logic [5:0]  op_q;
  logic [4:0]  dest_q;
  logic [1:0]  ea_lo_q;
  logic [31:0] ea;
  logic [31:0] ext_value;
  logic        accept;

  // Effective address wraps modulo 2^32
  assign ea     = bus.base + {{16{bus.offset[15]}}, bus.offset};
  assign accept = bus.req_valid && (state == S_IDLE);

  // Both status flags decode the state register, so they never glitch
  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

  load_extend u_load_extend (
    .opcode   (op_q),
    .byte_sel (ea_lo_q),
    .word     (bus.mem_rdata),
    .value    (ext_value)
  );

  // Load FSM with registered memory, writeback and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      op_q              <= 6'h0;
      dest_q            <= 5'd0;
      ea_lo_q           <= 2'd0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= 32'h0;
      bus.RegWrite      <= 1'b0;
      bus.rd            <= 5'd0;
      bus.write_data    <= 32'h0;
      bus.err           <= 1'b0;
    end else begin
      bus.err      <= 1'b0;
      bus.RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.opcode;
            dest_q  <= bus.dest;
            ea_lo_q <= ea[1:0];
            // Faulting loads report and stay idle without touching memory
            if (load_fault(bus.opcode, ea[1:0])) begin
              bus.err <= 1'b1;
            end else begin
              bus.mem_addr      <= {ea[31:2], 2'b00};
              bus.mem_req_valid <= 1'b1;
              state             <= S_MEM_REQ;
            end
          end
        end
        S_MEM_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            // r0 is hardwired to zero: the read still happens, no write
            if (dest_q != 5'd0) begin
              bus.RegWrite   <= 1'b1;
              bus.rd         <= dest_q;
              bus.write_data <= ext_value;
            end
            state <= S_WRITEBACK;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_load_writeback_unit.sv
// ============================================================================
// Module   : tb_load_writeback_unit
// Brief    : Directed self-checking bench for load_writeback_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  load_writeback_unit_if bus();

  load_writeback_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one load from IDLE and act as memory; inputs change and outputs
  // are sampled on falling edges.
  task automatic do_load(
    input  logic [5:0]  op,
    input  logic [31:0] b,
    input  logic [15:0] off,
    input  logic [4:0]  d,
    input  logic [31:0] rdata,
    input  int          rdy_dly,
    input  int          rv_dly,
    input  bit          junk,
    output int          writes,
    output logic [31:0] wd,
    output logic [4:0]  rdo,
    output logic [31:0] addr,
    output bit          stable,
    output int          req_cycles,
    output int          lat,
    output bit          done,
    output bit          rr_ok
  );
    bit hs;
    int wait_cnt;
    writes = 0; wd = '0; rdo = '0; addr = '0; stable = 1'b1;
    req_cycles = 0; lat = -1; done = 1'b0; rr_ok = 1'b1;
    hs = 1'b0; wait_cnt = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.opcode = op; bus.base = b;
    bus.offset = off; bus.dest = d;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      if (bus.busy && bus.req_ready) rr_ok = 1'b0;
      if (bus.RegWrite) begin
        writes++;
        wd  = bus.write_data;
        rdo = bus.rd;
        if (lat < 0) lat = cyc;
      end
      if (hs && !bus.busy) begin
        done = 1'b1;
        break;
      end
      if (bus.mem_req_valid) begin
        req_cycles++;
        if (req_cycles == 1) addr = bus.mem_addr;
        else if (bus.mem_addr !== addr) stable = 1'b0;
        bus.mem_req_ready = (req_cycles > rdy_dly);
        if (bus.mem_req_ready) hs = 1'b1;
        else if (junk) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'hDEADBEEF;
        end
      end else begin
        bus.mem_req_ready = 1'b0;
        if (hs) begin
          wait_cnt++;
          if (wait_cnt == rv_dly + 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
          end
        end
      end
    end
  endtask

  // Reset values while held and just after release
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.opcode = 6'h0; bus.base = 32'h0;
    bus.offset = 16'h0; bus.dest = 5'd0; bus.mem_req_ready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req_valid, bus.RegWrite, bus.err, bus.busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got valid/wr/err/busy=%b expected 0000",
               {bus.mem_req_valid, bus.RegWrite, bus.err, bus.busy});
    end
    checks++;
    if ({bus.rd, bus.write_data, bus.mem_addr} !== 69'h0) begin
      fails++;
      $display("FAIL reset_data: got rd=%0d wd=%h addr=%h expected all zero",
               bus.rd, bus.write_data, bus.mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_lbu();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h24, 32'h100, 16'h0003, 5'd14, 32'h8054B22B, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (a !== 32'h100) begin
      fails++; $display("FAIL lbu_addr: got %h expected 00000100", a);
    end
    checks++;
    if (!dn || w !== 1 || r !== 5'd14 || wd !== 32'h00000080) begin
      fails++;
      $display("FAIL lbu_write: done=%b writes=%0d rd=%0d wd=%h expected 1/1/14/00000080",
               dn, w, r, wd);
    end
    checks++;
    if (lat !== 3) begin
      fails++; $display("FAIL min_latency: got %0d cycles expected 3", lat);
    end
    checks++;
    if (!rr) begin
      fails++; $display("FAIL req_ready_while_busy: got ready high during busy expected low");
    end
  endtask

  task automatic test_lb();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h20, 32'h100, 16'h0003, 5'd14, 32'h8054B22B, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!dn || w !== 1 || wd !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL lb_sign: done=%b writes=%0d wd=%h expected 1/1/ffffff80", dn, w, wd);
    end
  endtask

  task automatic test_lh_lhu();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h25, 32'h100, 16'h0002, 5'd15, 32'h80011234, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!dn || w !== 1 || wd !== 32'h00008001 || a !== 32'h100) begin
      fails++;
      $display("FAIL lhu: writes=%0d wd=%h addr=%h expected 1/00008001/00000100", w, wd, a);
    end
    do_load(6'h21, 32'h100, 16'h0002, 5'd15, 32'h80011234, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!dn || w !== 1 || wd !== 32'hFFFF8001 || r !== 5'd15) begin
      fails++;
      $display("FAIL lh: writes=%0d wd=%h rd=%0d expected 1/ffff8001/15", w, wd, r);
    end
  endtask

  // r0 target: memory read happens, no write, outputs hold previous load
  task automatic test_dest_zero();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h23, 32'h200, 16'h0000, 5'd0, 32'hA5A5A5A5, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (rq < 1 || a !== 32'h200) begin
      fails++;
      $display("FAIL dest0_memreq: req_cycles=%0d addr=%h expected >=1 and 00000200", rq, a);
    end
    checks++;
    if (!dn || w !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL dest0_nowrite: done=%b writes=%0d busy=%b expected 1/0/0", dn, w, bus.busy);
    end
    checks++;
    if (bus.write_data !== 32'hFFFF8001 || bus.rd !== 5'd15) begin
      fails++;
      $display("FAIL dest0_hold: wd=%h rd=%0d expected ffff8001/15", bus.write_data, bus.rd);
    end
  endtask

  // Faulting requests: err pulse, no memory traffic, back-to-back acceptance
  task automatic test_misaligned();
    bit saw_mem = 1'b0;
    bit saw_wr  = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.opcode = 6'h23; bus.base = 32'h100;
    bus.offset = 16'h0001; bus.dest = 5'd5;
    @(negedge clk);
    saw_mem |= bus.mem_req_valid; saw_wr |= bus.RegWrite;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL lw_misaligned_err: err=%b busy=%b ready=%b expected 1/0/1",
               bus.err, bus.busy, bus.req_ready);
    end
    bus.opcode = 6'h22; bus.base = 32'h0; bus.offset = 16'h0; bus.dest = 5'd6;
    @(negedge clk);
    saw_mem |= bus.mem_req_valid; saw_wr |= bus.RegWrite;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL unsupported_err: err=%b busy=%b expected 1/0", bus.err, bus.busy);
    end
    bus.opcode = 6'h21; bus.base = 32'h103;
    @(negedge clk);
    saw_mem |= bus.mem_req_valid; saw_wr |= bus.RegWrite;
    checks++;
    if (bus.err !== 1'b1) begin
      fails++; $display("FAIL lh_odd_err: got %b expected 1", bus.err);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    saw_mem |= bus.mem_req_valid; saw_wr |= bus.RegWrite;
    checks++;
    if (bus.err !== 1'b0) begin
      fails++; $display("FAIL err_pulse_width: got %b expected 0", bus.err);
    end
    checks++;
    if (saw_mem || saw_wr) begin
      fails++;
      $display("FAIL fault_side_effects: mem_req=%b regwrite=%b expected 0/0", saw_mem, saw_wr);
    end
  endtask

  // Request stalled 5 cycles, read data 4 cycles late, junk rvalid while stalled
  task automatic test_stall();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h23, 32'h300, 16'h0004, 5'd7, 32'h12345678, 5, 4, 1'b1,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!st || a !== 32'h304 || rq !== 6) begin
      fails++;
      $display("FAIL stall_addr: stable=%b addr=%h req_cycles=%0d expected 1/00000304/6", st, a, rq);
    end
    checks++;
    if (!dn || w !== 1 || wd !== 32'h12345678 || r !== 5'd7 || lat !== 12) begin
      fails++;
      $display("FAIL stall_write: writes=%0d wd=%h rd=%0d lat=%0d expected 1/12345678/7/12",
               w, wd, r, lat);
    end
  endtask

  // Consecutive loads with a negative offset and a middle byte lane
  task automatic test_back_to_back();
    int w, rq, lat; logic [31:0] wd, a; logic [4:0] r; bit st, dn, rr;
    do_load(6'h23, 32'h208, 16'hFFF8, 5'd3, 32'hCAFEF00D, 0, 0, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!dn || a !== 32'h200 || w !== 1 || wd !== 32'hCAFEF00D || r !== 5'd3) begin
      fails++;
      $display("FAIL neg_offset_lw: addr=%h writes=%0d wd=%h rd=%0d expected 00000200/1/cafef00d/3",
               a, w, wd, r);
    end
    do_load(6'h20, 32'h100, 16'h0001, 5'd31, 32'h8054B22B, 1, 2, 1'b0,
            w, wd, r, a, st, rq, lat, dn, rr);
    checks++;
    if (!dn || w !== 1 || wd !== 32'hFFFFFFB2 || r !== 5'd31) begin
      fails++;
      $display("FAIL lb_lane1: writes=%0d wd=%h rd=%0d expected 1/ffffffb2/31", w, wd, r);
    end
  endtask

  // Reset in MEM_WAIT: immediate reset values, late read data ignored
  task automatic test_reset_mid();
    bit saw_wr = 1'b0;
    bit saw_busy = 1'b0;
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    bus.req_valid = 1'b1; bus.opcode = 6'h23; bus.base = 32'h400;
    bus.offset = 16'h0; bus.dest = 5'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reach_mem_wait: busy=%b mem_req_valid=%b expected 1/0", bus.busy, bus.mem_req_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_req_valid, bus.RegWrite, bus.err, bus.busy} !== 5'b10000 ||
        {bus.rd, bus.write_data, bus.mem_addr} !== 69'h0) begin
      fails++;
      $display("FAIL async_reset: ready/valid/wr/err/busy=%b rd=%0d wd=%h addr=%h expected 10000/0/0/0",
               {bus.req_ready, bus.mem_req_valid, bus.RegWrite, bus.err, bus.busy},
               bus.rd, bus.write_data, bus.mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    repeat (4) begin
      @(negedge clk);
      saw_wr |= bus.RegWrite; saw_busy |= bus.busy;
    end
    bus.mem_rvalid = 1'b0;
    checks++;
    if (saw_wr || saw_busy || bus.write_data !== 32'h0) begin
      fails++;
      $display("FAIL late_rvalid: regwrite=%b busy=%b wd=%h expected 0/0/00000000",
               saw_wr, saw_busy, bus.write_data);
    end
  endtask

  initial begin
    test_reset();
    test_lbu();
    test_lb();
    test_lh_lhu();
    test_dest_zero();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

`default_nettype wire
